// File: rtl/alu_issue.sv
// Single-entry ALU issue stage: operand fetch, 16-entry register scoreboard, registered issue slot.
// Optional writeback forwarding into the issue slot is enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_addr1,
  output logic [3:0]  rf_addr2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  ALUCtrl,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  dest,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        busy
);

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;

  typedef enum logic {EMPTY, FULL} slot_state_e;

  slot_state_e       state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [REG_W-1:0]  ctrl_q, dest_q;
  logic [NREG-1:0]   sb_q, sb_d;

  logic [REG_W-1:0]  op, rd, rs, rt;
  logic              fwd_rs, fwd_rt, fwd_rd;
  logic [DATA_W-1:0] op_a, op_b;
  logic              hazard, accept;

  assign op = instr[15:12];
  assign rd = instr[11:8];
  assign rs = instr[7:4];
  assign rt = instr[3:0];

  assign rf_addr1 = rs;
  assign rf_addr2 = rt;

`ifdef ALU_ISSUE_BYPASS_EN
  // A retiring write satisfies a source in the same cycle; for rd, set-wins keeps it pending on accept.
  assign fwd_rs = wb_valid && (wb_reg == rs);
  assign fwd_rt = wb_valid && (wb_reg == rt);
  assign fwd_rd = wb_valid && (wb_reg == rd);
  assign op_a   = fwd_rs ? wb_data : rf_data1;
  assign op_b   = fwd_rt ? wb_data : rf_data2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
  assign fwd_rd = 1'b0;
  assign op_a   = rf_data1;
  assign op_b   = rf_data2;
`endif

  // rd is part of the check so a younger write cannot overtake an older one (WAW).
  assign hazard = (sb_q[rs] && !fwd_rs) ||
                  (sb_q[rt] && !fwd_rt) ||
                  (sb_q[rd] && !fwd_rd);

  assign instr_ready = !rst && ((state_q == EMPTY) || issue_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Clear first, then set, so a same-cycle set on the retiring register wins.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid) sb_d[wb_reg] = 1'b0;
    if (accept)   sb_d[rd]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      sb_q    <= '0;
    end else begin
      sb_q <= sb_d;
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        ctrl_q <= op;
        dest_q <= rd;
      end
      unique case (state_q)
        EMPTY:   if (accept) state_q <= FULL;
        FULL:    if (!accept && issue_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign issue_valid = (state_q == FULL);
  assign ALUCtrl     = ctrl_q;
  assign A           = a_q;
  assign B           = b_q;
  assign dest        = dest_q;
  assign busy        = !rst && (|sb_q);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus a queue of expected issued operations.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, issue_valid, issue_ready;
  logic        wb_valid, busy;
  logic [15:0] instr;
  logic [3:0]  rf_addr1, rf_addr2, ALUCtrl, dest, wb_reg;
  logic [31:0] rf_data1, rf_data2, A, B, wb_data;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .ALUCtrl(ALUCtrl), .A(A), .B(B), .dest(dest),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
  );

  function automatic logic [31:0] rf_val(input logic [3:0] a);
    return 32'h0BAD_0000 + 32'h0101_0101 * {28'h0, a};
  endfunction

  assign rf_data1 = rf_val(rf_addr1);
  assign rf_data2 = rf_val(rf_addr2);

  // Expected issue payload {ctrl, dest, A, B} for an instruction accepted this cycle.
  function automatic logic [71:0] model(input logic [15:0] ins);
    logic [31:0] a, b;
    a = rf_val(ins[7:4]);
    b = rf_val(ins[3:0]);
    if (BYP && wb_valid && wb_reg == ins[7:4]) a = wb_data;
    if (BYP && wb_valid && wb_reg == ins[3:0]) b = wb_data;
    return {ins[15:12], ins[11:8], a, b};
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (issue_valid && issue_ready) begin
        check("issue_expected", 72'(exp_q.size() != 0), 72'd1);
        if (exp_q.size() != 0) check("issue_payload", {ALUCtrl, dest, A, B}, exp_q.pop_front());
      end
      if (instr_valid && instr_ready) exp_q.push_back(model(instr));
    end
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b1; instr = 16'hE123; issue_ready = 1'b1;
    wb_valid = 1'b0; wb_reg = 4'd0; wb_data = 32'd0;

    // Reset held with an instruction offered
    repeat (2) begin
      @(negedge clk);
      check("rst_issue_valid", 72'(issue_valid), 72'd0);
      check("rst_busy", 72'(busy), 72'd0);
      check("rst_ready", 72'(instr_ready), 72'd0);
      check("rst_A", 72'(A), 72'd0);
      tick();
    end
    rst = 1'b0; instr_valid = 1'b0;
    tick();

    // Back-to-back issue
    instr_valid = 1'b1; instr = 16'hE123;
    @(negedge clk);
    check("b2b_ready0", 72'(instr_ready), 72'd1);
    check("b2b_addr1", 72'(rf_addr1), 72'd2);
    check("b2b_addr2", 72'(rf_addr2), 72'd3);
    tick();
    instr = 16'hA456;
    @(negedge clk);
    check("b2b_ready1", 72'(instr_ready), 72'd1);
    check("b2b_issue0", 72'({issue_valid, ALUCtrl, dest}), 72'({1'b1, 4'hE, 4'd1}));
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_issue1", 72'({issue_valid, ALUCtrl, dest}), 72'({1'b1, 4'hA, 4'd4}));
    check("b2b_busy", 72'(busy), 72'd1);
    tick();
    wb_valid = 1'b1; wb_reg = 4'd1; tick();
    wb_reg = 4'd4; tick();
    wb_reg = 4'd9;
    @(negedge clk);
    check("wb_clear_busy", 72'(busy), 72'd0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("spurious_wb_busy", 72'(busy), 72'd0);
    check("idle_issue_valid", 72'(issue_valid), 72'd0);
    tick();

    // Backpressure on a held operation
    issue_ready = 1'b0; instr_valid = 1'b1; instr = 16'hB210;
    @(negedge clk);
    check("bp_ready_empty", 72'(instr_ready), 72'd1);
    tick();
    instr = 16'hE9AB;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", {ALUCtrl, dest, A, B}, {4'hB, 4'd2, rf_val(4'd1), rf_val(4'd0)});
      check("bp_ready", 72'(instr_ready), 72'd0);
      tick();
    end
    issue_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 72'(instr_ready), 72'd1);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("bp_next_issue", 72'({issue_valid, ALUCtrl, dest}), 72'({1'b1, 4'hE, 4'd9}));
    tick();
    wb_valid = 1'b1; wb_reg = 4'd2; tick();
    wb_reg = 4'd9; tick();
    wb_valid = 1'b0;

    // RAW hazard on r3
    instr_valid = 1'b1; instr = 16'hE312;
    @(negedge clk);
    check("raw_first_ready", 72'(instr_ready), 72'd1);
    tick();
    instr = 16'hD435;
    repeat (2) begin
      @(negedge clk);
      check("raw_stall", 72'(instr_ready), 72'd0);
      tick();
    end
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("raw_wb_cycle_ready", 72'(instr_ready), 72'(BYP));
    tick();
    wb_valid = 1'b0;
    if (BYP) instr_valid = 1'b0;
    @(negedge clk);
    if (BYP) begin
      check("raw_byp_issue", 72'({issue_valid, ALUCtrl, A}), 72'({1'b1, 4'hD, 32'hDEAD_BEEF}));
    end else begin
      check("raw_after_ready", 72'(instr_ready), 72'd1);
    end
    tick();
    instr_valid = 1'b0;
    if (!BYP) begin
      @(negedge clk);
      check("raw_issue", 72'({issue_valid, ALUCtrl, A}), 72'({1'b1, 4'hD, rf_val(4'd3)}));
    end
    wb_valid = 1'b1; wb_reg = 4'd4; tick();
    wb_valid = 1'b0; tick();
    @(negedge clk);
    check("raw_done_busy", 72'(busy), 72'd0);
    tick();

    // Set and clear of r5 in the same cycle
    instr_valid = 1'b1; instr = 16'hE512; wb_valid = 1'b1; wb_reg = 4'd5;
    @(negedge clk);
    check("coll_ready", 72'(instr_ready), 72'd1);
    tick();
    wb_valid = 1'b0; instr = 16'hE155;
    @(negedge clk);
    check("coll_busy", 72'(busy), 72'd1);
    check("coll_pending_r5", 72'(instr_ready), 72'd0);
    tick();
    instr_valid = 1'b0; wb_valid = 1'b1; wb_reg = 4'd5; tick();
    wb_valid = 1'b0; tick();

    // Reset while an operation is held and r7 is pending
    issue_ready = 1'b0; instr_valid = 1'b1; instr = 16'hE7AB;
    @(negedge clk);
    check("mid_accept", 72'(instr_ready), 72'd1);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid_full", 72'({issue_valid, busy}), 72'({1'b1, 1'b1}));
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 72'(instr_ready), 72'd0);
    tick();
    rst = 1'b0; issue_ready = 1'b1;
    @(negedge clk);
    check("mid_after_rst", 72'({issue_valid, busy}), 72'd0);
    tick();
    @(negedge clk);
    check("mid_no_issue", 72'(issue_valid), 72'd0);
    check("queue_drained", 72'(exp_q.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
